// File: rtl/inverter_chain_freq_meter_if.sv
// ----------------------------------------------------------------------------
// inverter_chain_freq_meter_if
//   Control/result bundle of the inverter-chain frequency meter.
//   master : requester side (drives start/ch_sel/gate_len, reads results)
//   slave  : meter side
//   Signals:
//     ch_sel   [CH_W]   channel to measure, sampled on accepted start
//     gate_len [GATE_W] window length in clk cycles, sampled on accepted start
//     start             measurement request (taken only while busy==0)
//     busy              measurement in progress
//     done              one-cycle pulse, count/overflow just updated
//     count    [CNT_W]  rising edges seen in the last window
//     overflow          last window saturated the counter
// ----------------------------------------------------------------------------
interface inverter_chain_freq_meter_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int GATE_W = 12
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CH_W-1:0]   ch_sel;
   logic [GATE_W-1:0] gate_len;
   logic              start;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output ch_sel, gate_len, start,
      input  busy, done, count, overflow
   );

   modport slave (
      input  ch_sel, gate_len, start,
      output busy, done, count, overflow
   );
endinterface

// File: rtl/inverter_chain_freq_meter.sv
// ----------------------------------------------------------------------------
// inverter_chain_freq_meter
//   Counts rising edges of one of NUM_CH asynchronous ring-oscillator /
//   inverter-chain outputs over a window of gate_len clk cycles.
//   Ports:
//     clk     clock
//     rst_n   asynchronous active-low reset
//     sig_in  [NUM_CH] asynchronous oscillator outputs
//     bus     control/result interface (slave modport)
//   Build option:
//     COUNT_SAT_EN  when defined the edge counter saturates at 2^CNT_W-1 and
//                   overflow reports it; otherwise the counter wraps and
//                   overflow is tied low.
// ----------------------------------------------------------------------------
module inverter_chain_freq_meter #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            sig_in,
   inverter_chain_freq_meter_if.slave   bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

   state_t                              state_q, state_d;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q;
   logic                                s_prev_q;
   logic [CH_W-1:0]                     ch_q, ch_d;
   logic [GATE_W-1:0]                   gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]                    edge_cnt_q, edge_cnt_d, edge_inc;
   logic [CNT_W-1:0]                    count_q, count_d;
   logic                                busy_q, busy_d;
   logic                                done_q, done_d;
   logic                                s_sel, rise;
`ifdef COUNT_SAT_EN
   logic                                ovf_q, ovf_d, ovf_inc;
   logic                                overflow_q, overflow_d;
`endif

   // Every channel is synchronised all the time; the mux sits after the
   // synchronisers so switching channels never samples a raw async pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         s_prev_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
         // Tracking the selected channel every cycle (including ARM) makes
         // the first MEASURE cycle compare against the new channel.
         s_prev_q <= s_sel;
      end
   end

   assign s_sel = sync_q[SYNC_STAGES-1][ch_q];
   assign rise  = s_sel & ~s_prev_q;

   // Edge counter increment, saturating or wrapping depending on build.
   always_comb begin
      edge_inc = edge_cnt_q;
`ifdef COUNT_SAT_EN
      ovf_inc  = ovf_q;
      if (rise) begin
         if (&edge_cnt_q) ovf_inc  = 1'b1;
         else             edge_inc = edge_cnt_q + CNT_W'(1);
      end
`else
      if (rise) edge_inc = edge_cnt_q + CNT_W'(1);
`endif
   end

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      count_d    = count_q;
      ch_d       = ch_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
`ifdef COUNT_SAT_EN
      ovf_d      = ovf_q;
      overflow_d = overflow_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Out-of-range selections fall back to channel 0.
               ch_d       = (32'(bus.ch_sel) >= NUM_CH) ? '0 : bus.ch_sel;
               gate_cnt_d = bus.gate_len;
               edge_cnt_d = '0;
`ifdef COUNT_SAT_EN
               ovf_d      = 1'b0;
`endif
               busy_d     = 1'b1;
               state_d    = ARM;
            end
         end
         ARM: begin
            if (gate_cnt_q == '0) begin
               count_d    = '0;
`ifdef COUNT_SAT_EN
               overflow_d = 1'b0;
`endif
               done_d     = 1'b1;
               state_d    = DONE;
            end else begin
               state_d    = MEASURE;
            end
         end
         MEASURE: begin
            edge_cnt_d = edge_inc;
`ifdef COUNT_SAT_EN
            ovf_d      = ovf_inc;
`endif
            gate_cnt_d = gate_cnt_q - GATE_W'(1);
            // Last window cycle: publish including this cycle's edge.
            if (gate_cnt_q == GATE_W'(1)) begin
               count_d    = edge_inc;
`ifdef COUNT_SAT_EN
               overflow_d = ovf_inc;
`endif
               done_d     = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
         ch_q       <= '0;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
`ifdef COUNT_SAT_EN
         ovf_q      <= 1'b0;
         overflow_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
         ch_q       <= ch_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
`ifdef COUNT_SAT_EN
         ovf_q      <= ovf_d;
         overflow_q <= overflow_d;
`endif
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.count = count_q;
`ifdef COUNT_SAT_EN
   assign bus.overflow = overflow_q;
`else
   assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_inverter_chain_freq_meter.sv
// ----------------------------------------------------------------------------
// tb_inverter_chain_freq_meter
//   Two meters share the same pins: A (NUM_CH=4, CNT_W=16) and
//   B (NUM_CH=3, CNT_W=4) so the narrow counter and the out-of-range channel
//   fallback are both exercised. Expected counts come from the recorded pin
//   history: rising transitions of the pin as sampled on clk, inside a
//   gate_len-cycle window that sits SYNC_STAGES cycles behind the pins.
// ----------------------------------------------------------------------------
module tb_inverter_chain_freq_meter;
   localparam int NCH   = 4;
   localparam int CW    = 16;
   localparam int GW    = 12;
   localparam int SS    = 2;
   localparam int NCH_B = 3;
   localparam int CW_B  = 4;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] sig_in = '0;

   always #5 clk = ~clk;

   inverter_chain_freq_meter_if #(.NUM_CH(NCH),   .CNT_W(CW),   .GATE_W(GW)) bus_a ();
   inverter_chain_freq_meter_if #(.NUM_CH(NCH_B), .CNT_W(CW_B), .GATE_W(GW)) bus_b ();

   inverter_chain_freq_meter #(.NUM_CH(NCH), .CNT_W(CW), .GATE_W(GW), .SYNC_STAGES(SS)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus_a.slave));

   inverter_chain_freq_meter #(.NUM_CH(NCH_B), .CNT_W(CW_B), .GATE_W(GW), .SYNC_STAGES(SS)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in[NCH_B-1:0]), .bus(bus_b.slave));

   int tests = 0;
   int fails = 0;

   // Pin history, one entry per rising clk edge.
   logic [NCH-1:0] hist [0:65535];
   int cyc_n = 0;
   always @(posedge clk) begin
      hist[cyc_n] <= sig_in;
      cyc_n       <= cyc_n + 1;
   end

   // Per-channel waveform: per>0 square wave, per==0 constant lvl, per<0 random bits.
   int   per [NCH];
   int   ph  [NCH];
   logic lvl [NCH];

   initial begin
      for (int c = 0; c < NCH; c++) begin per[c] = 0; ph[c] = 0; lvl[c] = 1'b0; end
      forever begin
         @(negedge clk);
         for (int c = 0; c < NCH; c++) begin
            if (per[c] > 0)       sig_in[c] = (((cyc_n + ph[c]) % per[c]) < (per[c] / 2));
            else if (per[c] == 0) sig_in[c] = lvl[c];
            else                  sig_in[c] = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic set_pat(input int p);
      for (int c = 0; c < NCH; c++) begin
         case (p)
            0: begin per[c] = 4; ph[c] = c; end
            1: begin per[c] = (c == 0) ? 0 : 2 + c; lvl[c] = 1'b1; ph[c] = 0; end
            2: begin per[c] = (c == 0 || c == 2) ? 0 : 3; lvl[c] = (c == 2); ph[c] = c; end
            default: begin
               per[c] = int'($urandom_range(0, 9)) - 1;
               if (per[c] == 1) per[c] = 2;
               lvl[c] = 1'($urandom_range(0, 1));
               ph[c]  = int'($urandom_range(0, 7));
            end
         endcase
      end
   endtask

   // Reference: rising transitions of the sampled pin inside the window.
   function automatic int model_cnt(input int t, input int g, input int ch, input int nch);
      int eff = (ch >= nch) ? 0 : ch;
      int n   = 0;
      for (int j = t + 2 - SS; j <= t + 1 + g - SS; j++)
         if (hist[j][eff] && !hist[j-1][eff]) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic drive(input logic st, input int ch, input int g);
      bus_a.start = st; bus_a.ch_sel = 2'(ch); bus_a.gate_len = 12'(g);
      bus_b.start = st; bus_b.ch_sel = 2'(ch); bus_b.gate_len = 12'(g);
   endtask

   // Called and returns on a falling edge; returns one cycle after done,
   // so an immediate following call is a back-to-back start.
   task automatic measure(input int ch, input int g, input int hold, output int t0, output int lat,
                          output logic [CW-1:0] ca, output logic oa,
                          output logic [CW_B-1:0] cb, output logic ob);
      drive(1'b1, ch, g);
      t0 = cyc_n; lat = -1; ca = '0; oa = 1'b0; cb = '0; ob = 1'b0;
      for (int n = 1; n <= g + 10 && lat < 0; n++) begin
         @(negedge clk);
         if (n >= hold) begin bus_a.start = 1'b0; bus_b.start = 1'b0; end
         if (n == 1) chk("busy_after_start", bus_a.busy, 1'b1);
         if (bus_a.done === 1'b1) begin
            lat = n; ca = bus_a.count; oa = bus_a.overflow;
            cb = bus_b.count; ob = bus_b.overflow;
            chk("done_b_aligned", bus_b.done, 1'b1);
         end
      end
      @(negedge clk);
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      chk("done_one_cycle", bus_a.done, 1'b0);
      chk("busy_low_after_done", bus_a.busy, 1'b0);
   endtask

   task automatic run_chk(input string name, input int ch, input int g, input int hold,
                          input int lo, input int hi);
      int t0, lat, ea, eb;
      logic [CW-1:0] ca; logic oa; logic [CW_B-1:0] cb; logic ob;
      measure(ch, g, hold, t0, lat, ca, oa, cb, ob);
      ea = model_cnt(t0, g, ch, NCH);
      eb = model_cnt(t0, g, ch, NCH_B);
      chk({name, "_latency"}, lat, g + 2);
      chk({name, "_count_a"}, ca, 32'(ea[CW-1:0]));
      chk({name, "_ovf_a"}, oa, 1'b0);
`ifdef COUNT_SAT_EN
      chk({name, "_count_b"}, cb, (eb > 15) ? 15 : eb);
      chk({name, "_ovf_b"}, ob, (eb > 15) ? 1 : 0);
`else
      chk({name, "_count_b"}, cb, eb % 16);
      chk({name, "_ovf_b"}, ob, 1'b0);
`endif
      if (lo >= 0) chk_range({name, "_range_a"}, int'(ca), lo, hi);
   endtask

   typedef struct {
      int    pat;
      int    ch;
      int    g;
      int    lo;
      int    hi;
      string name;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int npulse;
      tbl[0] = '{pat: 0, ch: 1, g: 100, lo: 24, hi: 26, name: "sq4_ch1"};
      tbl[1] = '{pat: 1, ch: 0, g: 50,  lo: 0,  hi: 0,  name: "ch0_high"};
      tbl[2] = '{pat: 2, ch: 0, g: 20,  lo: 0,  hi: 0,  name: "ch0_low"};
      tbl[3] = '{pat: 2, ch: 2, g: 50,  lo: 0,  hi: 0,  name: "switch_ch2_high"};
      tbl[4] = '{pat: 0, ch: 3, g: 37,  lo: 8,  hi: 10, name: "sq4_ch3"};

      drive(1'b0, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset_busy", bus_a.busy, 1'b0);
      chk("reset_done", bus_a.done, 1'b0);
      chk("reset_count", bus_a.count, 0);
      chk("reset_overflow", bus_a.overflow, 1'b0);
      rst_n = 1'b1;
      set_pat(0);
      repeat (8) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         set_pat(tbl[i].pat);
         repeat (6) @(negedge clk);
         run_chk(tbl[i].name, tbl[i].ch, tbl[i].g, 1, tbl[i].lo, tbl[i].hi);
      end

      // Zero-length gate with start held through busy: one done only.
      set_pat(0);
      run_chk("gate0", 1, 0, 3, 0, 0);
      npulse = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1) npulse++;
      end
      chk("gate0_no_extra_done", npulse, 0);

      // Out-of-range channel on B, then back-to-back accepted starts.
      run_chk("b2b_first", 3, 10, 1, 1, 4);
      run_chk("b2b_second", 1, 7, 1, -1, -1);

      // Randomized runs.
      for (int i = 0; i < 12; i++) begin
         set_pat(3);
         repeat (4) @(negedge clk);
         run_chk("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 80)), 1, -1, -1);
      end

      // Reset in the middle of MEASURE.
      set_pat(0);
      run_chk("pre_reset", 1, 40, 1, 9, 11);
      drive(1'b1, 1, 100);
      @(negedge clk);
      drive(1'b0, 1, 100);
      repeat (20) @(negedge clk);
      chk("midrun_busy", bus_a.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_busy", bus_a.busy, 1'b0);
      chk("midrun_reset_done", bus_a.done, 1'b0);
      chk("midrun_reset_count", bus_a.count, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      npulse = 0;
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         if (bus_a.done === 1'b1) npulse++;
      end
      chk("reset_no_done", npulse, 0);
      chk("reset_idle_busy", bus_a.busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1);
   end

endmodule
